core_muldiv: RTL

- Iterative multiply/divide unit in the execute stage, directly downstream of the registered operand select stage.
- Consumes the registered operand_a/operand_b pair together with a start strobe and op code.
- Computes one result over multiple cycles with a radix-2 shift-add multiplier or a restoring divider.
- Signals busy so the pipeline controller stalls issue, and pulses done with the registered result for writeback.

---
 rtl/core_muldiv.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/core_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one 2*WIDTH accumulator, with busy/done handshake.
module core_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_REMU  = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;

    state_t             state_reg;
    logic [2:0]         op_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;     // multiply: {hi, lo}; divide: {rem, quo}
    logic [WIDTH-1:0]   opnd_reg;    // multiplicand or divisor magnitude
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   result_reg;

    logic               is_mul_in;
    logic               is_signed_in;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   result_next;

    always_comb begin
        is_mul_in    = (op == OP_MUL) || (op == OP_MULHU);
        is_signed_in = (op == OP_DIV) || (op == OP_REM);
        a_neg        = is_signed_in && operand_a[WIDTH-1];
        b_neg        = is_signed_in && operand_b[WIDTH-1];
        abs_a        = a_neg ? -operand_a : operand_a;
        abs_b        = b_neg ? -operand_b : operand_b;

        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + ({(WIDTH+1){acc_reg[0]}} & {1'b0, opnd_reg});
        mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

        // Remainder needs one extra bit after the shift before the trial subtract.
        rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        diff     = rem_sh - {1'b0, opnd_reg};
        div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   acc_reg[WIDTH-2:0], 1'b1};

        quo_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

        case (op_reg)
            OP_MUL:            result_next = acc_reg[WIDTH-1:0];
            OP_MULHU:          result_next = acc_reg[2*WIDTH-1:WIDTH];
            OP_DIVU, OP_DIV:   result_next = quo_fix;
            default:           result_next = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !flush && (op <= OP_REM)) begin
                        op_reg   <= op;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        if (is_mul_in) begin
                            acc_reg   <= {{WIDTH{1'b0}}, operand_b};
                            opnd_reg  <= operand_a;
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                            state_reg <= CALC;
                        end else if (operand_b == '0) begin
                            // Preload the divide-by-zero answers; no fixup applies.
                            acc_reg   <= {operand_a, {WIDTH{1'b1}}};
                            opnd_reg  <= '0;
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                            state_reg <= FIN;
                        end else begin
                            acc_reg   <= {{WIDTH{1'b0}}, abs_a};
                            opnd_reg  <= abs_b;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg <= (op_reg[2:1] == 2'b00) ? mul_next : div_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(WIDTH-1))
                            state_reg <= FIN;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (!flush) begin
                        result_reg <= result_next;
                        done_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
endmodule
